// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit:
// operation codes, latencies and FSM states.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } md_op_e;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MULT_CYCLES = 4'd5;
  localparam logic [CNT_W-1:0] DIV_CYCLES  = 4'd10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath.
// Produces {hi, lo} for the latched operation.
module md_calc
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [63:0] res,
  output logic        div_by_zero
);

  logic        sgn;
  logic        neg_a;
  logic        neg_b;
  logic [63:0] ea;
  logic [63:0] eb;
  logic [63:0] prod;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] q;
  logic [31:0] r;

  always_comb begin
    sgn   = (op == OP_MULT) || (op == OP_DIV);
    ea    = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb    = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = ea * eb;

    // Divide on magnitudes; 0x80000000 maps onto itself,
    // so the -2^31 / -1 overflow case falls out naturally.
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    ma    = neg_a ? (~a + 32'd1) : a;
    mb    = neg_b ? (~b + 32'd1) : b;

    div_by_zero = is_div(op) && (b == 32'd0);
    q = (mb == 32'd0) ? 32'd0 : ma / mb;
    r = (mb == 32'd0) ? 32'd0 : ma % mb;
    if (neg_a ^ neg_b) q = ~q + 32'd1;
    if (neg_a)         r = ~r + 32'd1;

    res = 64'd0;
    unique case (1'b1)
      is_mul(op): res = prod;
      is_div(op): res = {r, q};
      default:    res = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results commit atomically on the cycle Busy falls.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  state_e           state;
  state_e           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [3:0]       op_q;
  logic             load;
  logic             wr_res;
  logic             wr_hi;
  logic             wr_lo;
  logic [63:0]      res;
  logic             dbz;

  md_calc u_calc (
    .a           (a_q),
    .b           (b_q),
    .op          (op_q),
    .res         (res),
    .div_by_zero (dbz)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    wr_res  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Start) begin
          unique case (1'b1)
            is_mul(MDOp): begin
              load    = 1'b1;
              cnt_n   = MULT_CYCLES;
              state_n = S_RUN;
            end
            is_div(MDOp): begin
              load    = 1'b1;
              cnt_n   = DIV_CYCLES;
              state_n = S_RUN;
            end
            (MDOp == OP_MTHI): wr_hi = 1'b1;
            (MDOp == OP_MTLO): wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_n = cnt - 1'b1;
        if (cnt == 4'd1) begin
          state_n = S_IDLE;
          wr_res  = !dbz;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= MDOp;
      end
      if (wr_res) begin
        HI <= res[63:32];
        LO <= res[31:0];
      end
      if (wr_hi) HI <= A;
      if (wr_lo) LO <= A;
    end
  end

  assign Busy = (state == S_RUN);

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and reset_n (0 = reset).
REQ-002 Port: clk  in  1  system clock, rising-edge active.
REQ-003 Port: reset_n  in  1  asynchronous active-low reset.
REQ-004 Port: A  in  32  operand 1 (rs value); dividend or multiplicand; source for mthi/mtlo.
REQ-005 Port: B  in  32  operand 2 (rt value); divisor or multiplier.
REQ-006 Port: MDOp  in  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7-15 treated as none.
REQ-007 Port: Start  in  1  single-cycle request qualifier; MDOp is sampled only when Start=1.
REQ-008 Port: Busy  out  1  high while a mult/div is in flight.
REQ-009 Port: HI  out  32  architectural HI register.
REQ-010 Port: LO  out  32  architectural LO register.

Function
REQ-011 Two states: IDLE and RUN; IDLE on reset.
REQ-012 IDLE, Start=1, MDOp in {1,2}: latch operands, load counter with MULT_CYCLES=5, go to RUN.
REQ-013 IDLE, Start=1, MDOp in {3,4}: latch operands, load counter with DIV_CYCLES=10, go to RUN.
REQ-014 Busy SHALL be 1 from the cycle after the accepting edge through exactly N cycles (N=5 or 10), then 0.
REQ-015 RUN: decrement counter each cycle; on the edge where it reaches 0, write HI/LO and return to IDLE; new values visible the same cycle Busy falls.
REQ-016 HI/LO SHALL hold their previous values throughout RUN; no partial results visible.
REQ-017 mult: signed 32x32 -> 64; HI = bits 63:32, LO = bits 31:0.
REQ-018 multu: unsigned 32x32 -> 64, same split.
REQ-019 div: LO = signed quotient truncated toward zero; HI = remainder with sign of dividend.
REQ-020 div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-021 divu: LO = unsigned quotient, HI = unsigned remainder.
REQ-022 Divide by zero (B=0, op 3 or 4): full N-cycle Busy sequence; HI and LO unchanged at completion.
REQ-023 mthi/mtlo (Start=1, IDLE): write A to HI/LO at that edge; Busy stays 0; the other register is unchanged.
REQ-024 Start=1 while Busy=1 or in RUN: ignored for every MDOp (upstream stalls); in-flight operation unaffected.
REQ-025 Start=1 with MDOp 0 or 7-15: no state change.
REQ-026 Operand changes on A/B during RUN SHALL NOT affect the result.

Reset
REQ-027 reset_n=0 SHALL asynchronously force HI=0, LO=0, Busy=0, counter=0, state=IDLE.
REQ-028 Reset asserted mid-RUN SHALL abort the operation; no result is written after reset_n releases.
REQ-029 After reset_n rises, the first Start is accepted at the next rising edge.

Structure
REQ-030 Package mdu_pkg SHALL hold the MDOp codes, MULT_CYCLES, DIV_CYCLES, and the state enum.
REQ-031 Arithmetic SHALL be split into one combinational sub-module, md_calc (latched operands + op in, 64-bit {hi,lo} and div_by_zero out); mdu holds the FSM, counter and HI/LO.

Verification
REQ-032 mult A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 multu A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 div A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 with HI/LO preset -> values unchanged after 10 cycles.
REQ-035 mthi A=0x12345678 -> HI=0x12345678 next edge, Busy stays 0; mtlo issued at cycle 2 of a mult -> ignored; LO = mult result.
REQ-036 reset_n pulsed low at cycle 3 of a div -> HI=LO=0, Busy=0 immediately; no later write; a mult issued after release completes normally.
REQ-037 div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; back-to-back Start on the Busy-fall cycle -> accepted.
